// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared pixel width, source-mux FSM encoding and pixel defaults
package vga_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_BLANK      = 2'd2
    } mux_state_t;

    localparam int   BLANK_CNT_W     = 4;
    // Fill bits for the width-generic default and key pixels.
    localparam logic DEFAULT_PIX_BIT = 1'b1;
    localparam logic KEY_PIX_BIT     = 1'b0;

    function automatic int pix_w(input int cw);
        return 3 * cw;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous control inputs
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vga_source_mux.sv
// rtl/vga_source_mux.sv - frame-synchronous pixel source selector with colour-key overlay
module vga_source_mux
    import vga_pkg::*;
#(
    parameter int                     NUM_SRC      = 4,
    parameter int                     CW           = 4,
    parameter int                     SEL_W        = 3,
    parameter int                     BLANK_FRAMES = 1,
    parameter logic [pix_w(CW)-1:0]   DEFAULT_PIX  = {pix_w(CW){DEFAULT_PIX_BIT}},
    parameter logic [pix_w(CW)-1:0]   KEY_PIX      = {pix_w(CW){KEY_PIX_BIT}}
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC*pix_w(CW)-1:0]   src_pix,
    input  logic                           pix_active,
    input  logic                           frame_start,
    input  logic [SEL_W-1:0]               sel,
    input  logic                           ovl_en,
    input  logic [SEL_W-1:0]               ovl_sel,
    output logic [pix_w(CW)-1:0]           o_pix,
    output logic                           o_active,
    output logic [SEL_W-1:0]               cur_sel,
    output logic                           switching
);

    localparam int PW = pix_w(CW);
    localparam logic [BLANK_CNT_W-1:0] BLANK_LOAD = BLANK_CNT_W'(BLANK_FRAMES - 1);

    logic [SEL_W-1:0]       sel_s, ovl_sel_s;
    logic                   ovl_en_s;
    mux_state_t             state, state_next;
    logic [SEL_W-1:0]       pend_sel, pend_sel_next, cur_sel_next;
    logic [BLANK_CNT_W-1:0] blank_cnt, blank_cnt_next;

    sync_2ff #(.W(SEL_W)) u_sync_sel     (.clk(clk), .rst(rst), .d(sel),     .q(sel_s));
    sync_2ff #(.W(1))     u_sync_ovl_en  (.clk(clk), .rst(rst), .d(ovl_en),  .q(ovl_en_s));
    sync_2ff #(.W(SEL_W)) u_sync_ovl_sel (.clk(clk), .rst(rst), .d(ovl_sel), .q(ovl_sel_s));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            cur_sel   <= '0;
            pend_sel  <= '0;
            blank_cnt <= '0;
        end else begin
            state     <= state_next;
            cur_sel   <= cur_sel_next;
            pend_sel  <= pend_sel_next;
            blank_cnt <= blank_cnt_next;
        end
    end

    // Switches are only committed on frame_start so a frame is never torn.
    always_comb begin
        state_next     = state;
        cur_sel_next   = cur_sel;
        pend_sel_next  = pend_sel;
        blank_cnt_next = blank_cnt;
        unique case (state)
            ST_RUN: begin
                if (sel_s != cur_sel) begin
                    state_next    = ST_WAIT_FRAME;
                    pend_sel_next = sel_s;
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_start) begin
                    if (BLANK_FRAMES > 0) begin
                        state_next     = ST_BLANK;
                        blank_cnt_next = BLANK_LOAD;
                    end else begin
                        state_next   = ST_RUN;
                        cur_sel_next = pend_sel;
                    end
                end
            end
            ST_BLANK: begin
                if (frame_start) begin
                    if (blank_cnt == '0) begin
                        state_next   = ST_RUN;
                        cur_sel_next = pend_sel;
                    end else begin
                        blank_cnt_next = blank_cnt - 1'b1;
                    end
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    logic              cur_ok, ovl_ok;
    logic [SEL_W-1:0]  cur_idx, ovl_idx;
    logic [PW-1:0]     base_src, ovl_src, mux_pix;

    // Indices are clamped so the part-selects never leave the bus.
    assign cur_ok   = 32'(cur_sel) < NUM_SRC;
    assign ovl_ok   = 32'(ovl_sel_s) < NUM_SRC;
    assign cur_idx  = cur_ok ? cur_sel : '0;
    assign ovl_idx  = ovl_ok ? ovl_sel_s : '0;
    assign base_src = src_pix[32'(cur_idx)*PW +: PW];
    assign ovl_src  = src_pix[32'(ovl_idx)*PW +: PW];

    always_comb begin
        mux_pix = cur_ok ? base_src : DEFAULT_PIX;
        if (state == ST_BLANK) begin
            mux_pix = '0;
        end
        if (ovl_en_s && ovl_ok && (state != ST_BLANK) && (ovl_src != KEY_PIX)) begin
            mux_pix = ovl_src;
        end
        if (!pix_active) begin
            mux_pix = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pix     <= '0;
            o_active  <= 1'b0;
            switching <= 1'b0;
        end else begin
            o_pix     <= mux_pix;
            o_active  <= pix_active;
            switching <= (state_next != ST_RUN);
        end
    end

endmodule

// File: tb/tb_vga_source_mux.sv
// tb/tb_vga_source_mux.sv - randomized bench for vga_source_mux against a frame-level reference model
module tb_vga_source_mux;

    localparam int NS = 4;
    localparam int CW = 4;
    localparam int PW = 12;
    localparam int SW = 3;
    localparam int H_TOTAL = 16;
    localparam int V_TOTAL = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NS*PW-1:0]  src_pix = '0;
    logic              pix_active = 1'b0;
    logic              frame_start = 1'b0;
    logic [SW-1:0]     sel = '0;
    logic              ovl_en = 1'b0;
    logic [SW-1:0]     ovl_sel = '0;

    logic [PW-1:0]     o_pix_d    [2];
    logic              o_active_d [2];
    logic [SW-1:0]     cur_sel_d  [2];
    logic              switching_d[2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_source_mux #(.NUM_SRC(NS), .CW(CW), .SEL_W(SW), .BLANK_FRAMES(0)) u_dut_b0 (
        .clk(clk), .rst(rst), .src_pix(src_pix), .pix_active(pix_active),
        .frame_start(frame_start), .sel(sel), .ovl_en(ovl_en), .ovl_sel(ovl_sel),
        .o_pix(o_pix_d[0]), .o_active(o_active_d[0]), .cur_sel(cur_sel_d[0]),
        .switching(switching_d[0])
    );

    vga_source_mux #(.NUM_SRC(NS), .CW(CW), .SEL_W(SW), .BLANK_FRAMES(2)) u_dut_b2 (
        .clk(clk), .rst(rst), .src_pix(src_pix), .pix_active(pix_active),
        .frame_start(frame_start), .sel(sel), .ovl_en(ovl_en), .ovl_sel(ovl_sel),
        .o_pix(o_pix_d[1]), .o_active(o_active_d[1]), .cur_sel(cur_sel_d[1]),
        .switching(switching_d[1])
    );

    // Reference model: pins reach the logic two clocks late; a switch needs
    // (blank frames + 1) frame_start pulses after acceptance, and the frames
    // between the first pulse and the last are shown black.
    logic [SW-1:0] pin_sel_q [2];
    logic [SW-1:0] pin_os_q  [2];
    logic          pin_en_q  [2];
    bit            m_busy [2];
    int            m_left [2];
    logic [SW-1:0] m_cur  [2];
    logic [SW-1:0] m_tgt  [2];
    logic [PW-1:0] e_pix  [2];
    logic          e_act;

    function automatic int blanks_of(input int b);
        return (b == 0) ? 0 : 2;
    endfunction

    function automatic logic [PW-1:0] src_of(input logic [SW-1:0] i);
        return src_pix[int'(i)*PW +: PW];
    endfunction

    function automatic logic [PW-1:0] model_pix(input int b);
        bit blank;
        logic [PW-1:0] p;
        blank = m_busy[b] && (m_left[b] <= blanks_of(b));
        if (blank)
            p = '0;
        else if (int'(m_cur[b]) < NS)
            p = src_of(m_cur[b]);
        else
            p = 12'hFFF;
        if (pin_en_q[1] && int'(pin_os_q[1]) < NS && !blank && src_of(pin_os_q[1]) != 12'h000)
            p = src_of(pin_os_q[1]);
        if (!pix_active)
            p = '0;
        return p;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                pin_sel_q[k] <= '0;
                pin_os_q[k]  <= '0;
                pin_en_q[k]  <= 1'b0;
                m_busy[k]    <= 1'b0;
                m_left[k]    <= 0;
                m_cur[k]     <= '0;
                m_tgt[k]     <= '0;
                e_pix[k]     <= '0;
            end
            e_act <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                e_pix[b] <= model_pix(b);
                if (!m_busy[b]) begin
                    if (pin_sel_q[1] != m_cur[b]) begin
                        m_busy[b] <= 1'b1;
                        m_tgt[b]  <= pin_sel_q[1];
                        m_left[b] <= blanks_of(b) + 1;
                    end
                end else if (frame_start) begin
                    if (m_left[b] == 1) begin
                        m_busy[b] <= 1'b0;
                        m_cur[b]  <= m_tgt[b];
                        m_left[b] <= 0;
                    end else begin
                        m_left[b] <= m_left[b] - 1;
                    end
                end
            end
            e_act        <= pix_active;
            pin_sel_q[0] <= sel;
            pin_sel_q[1] <= pin_sel_q[0];
            pin_os_q[0]  <= ovl_sel;
            pin_os_q[1]  <= pin_os_q[0];
            pin_en_q[0]  <= ovl_en;
            pin_en_q[1]  <= pin_en_q[0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        for (int b = 0; b < 2; b++) begin
            chk(b == 0 ? "o_pix_b0" : "o_pix_b2", 32'(o_pix_d[b]), 32'(e_pix[b]));
            chk(b == 0 ? "o_active_b0" : "o_active_b2", 32'(o_active_d[b]), 32'(e_act));
            chk(b == 0 ? "cur_sel_b0" : "cur_sel_b2", 32'(cur_sel_d[b]), 32'(m_cur[b]));
            chk(b == 0 ? "switching_b0" : "switching_b2", 32'(switching_d[b]), 32'(m_busy[b]));
        end
    endtask

    int h = 0;
    int v = 0;
    int mode = 0;
    bit tog = 1'b0;

    task automatic drive_src();
        logic [31:0] r;
        for (int i = 0; i < NS; i++) begin
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r = '0;
            src_pix[i*PW +: PW] = r[PW-1:0];
        end
        if (mode == 1) begin
            tog = ~tog;
            src_pix[0*PW +: PW] = 12'h00F;
            src_pix[1*PW +: PW] = tog ? 12'hF00 : 12'h000;
            src_pix[2*PW +: PW] = 12'h0F0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        h = h + 1;
        if (h == H_TOTAL) begin
            h = 0;
            v = (v + 1 == V_TOTAL) ? 0 : v + 1;
        end
        frame_start = (h == 0) && (v == 0);
        pix_active  = (h < 12) && (v < 4);
        drive_src();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int b = 0; b < 2; b++) begin
            chk("rst_o_pix", 32'(o_pix_d[b]), 32'h0);
            chk("rst_o_active", 32'(o_active_d[b]), 32'h0);
            chk("rst_cur_sel", 32'(cur_sel_d[b]), 32'h0);
            chk("rst_switching", 32'(switching_d[b]), 32'h0);
        end
        run(3);
        rst = 1'b0;
    endtask

    localparam int FRAME = H_TOTAL * V_TOTAL;

    initial begin
        mode = 1;
        drive_src();
        run(4);
        pulse_reset();

        // Switch 0 -> 2 mid-frame.
        run(FRAME + 40);
        sel = 3'd2;
        run(5 * FRAME);
        chk("sw_to2_b0", 32'(cur_sel_d[0]), 32'd2);
        chk("sw_to2_b2", 32'(cur_sel_d[1]), 32'd2);

        // Switch to 1, then 1 -> 3 with random sources.
        mode = 0;
        sel = 3'd1;
        run(5 * FRAME);
        sel = 3'd3;
        run(5 * FRAME);
        chk("sw_to3_b2", 32'(cur_sel_d[1]), 32'd3);

        // Out-of-range base source.
        sel = 3'd5;
        run(5 * FRAME);
        chk("oor_sel_b2", 32'(cur_sel_d[1]), 32'd5);

        // Overlay keying over source 0, then a request during blanking.
        mode = 1;
        sel = 3'd0;
        ovl_en = 1'b1;
        ovl_sel = 3'd1;
        run(5 * FRAME);
        sel = 3'd1;
        run(150);
        sel = 3'd2;
        run(8 * FRAME);
        chk("blank_req_b0", 32'(cur_sel_d[0]), 32'd2);
        chk("blank_req_b2", 32'(cur_sel_d[1]), 32'd2);

        // Randomized selects and overlay settings.
        for (int it = 0; it < 30; it++) begin
            mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            sel = 3'($urandom_range(0, 7));
            ovl_en = 1'($urandom_range(0, 1));
            ovl_sel = 3'($urandom_range(0, 7));
            run($urandom_range(20, 200));
        end

        // Reset in the middle of a switch.
        sel = 3'd0;
        run(4 * FRAME);
        sel = 3'd3;
        run(FRAME + 20);
        pulse_reset();
        run(5 * FRAME);
        chk("post_rst_b2", 32'(cur_sel_d[1]), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_source_mux.md
# vga_source_mux

Parametrised, frame-synchronous pixel-source selector with colour-key overlay, sitting between the pixel generators (ROM image, colour strip, UART/SRAM frame) and `vga_display`. It replaces the combinational `output_select` case mux. A selection change takes effect only at a frame boundary, optionally after a number of blanked frames, so the monitor never sees a torn frame. All outputs are registered.

## Interface
Parameters:
- `NUM_SRC`, 4: number of pixel sources, 2..8.
- `CW`, 4: bits per colour channel. A pixel is 3*CW bits, packed {r,g,b}.
- `SEL_W`, 3: width of the select inputs.
- `BLANK_FRAMES`, 1: blank frames inserted on a source switch, 0..15.
- `DEFAULT_PIX`, all ones: pixel output for an out-of-range select.
- `KEY_PIX`, 0: overlay transparency colour.

Ports:
- `clk` in 1: pixel clock, the divided clock.
- `rst` in 1: asynchronous, active-high reset.
- `src_pix` in NUM_SRC*3*CW: source pixels. Source i occupies bits [(i+1)*3*CW-1 : i*3*CW].
- `pix_active` in 1: current h/v count is inside the visible area.
- `frame_start` in 1: one-cycle pulse at the first pixel clock of each frame.
- `sel` in SEL_W: requested base source. Asynchronous (switches).
- `ovl_en` in 1: overlay enable. Asynchronous.
- `ovl_sel` in SEL_W: overlay source index. Asynchronous.
- `o_pix` out 3*CW: output pixel {r,g,b}.
- `o_active` out 1: `pix_active` delayed to stay aligned with `o_pix`.
- `cur_sel` out SEL_W: base source currently displayed.
- `switching` out 1: high from request acceptance until the new source is live.

## Operation
- **Input synchronisation:** `sel`, `ovl_en` and `ovl_sel` each pass through a 2-flop synchroniser. Call the results `sel_s`, `ovl_en_s`, `ovl_sel_s`.
- **Change request:** a request is pending when `sel_s != cur_sel` and the FSM is in RUN. The target `pend_sel` is latched the cycle the FSM leaves RUN.
- **FSM states:** RUN, WAIT_FRAME, BLANK.
  - RUN → WAIT_FRAME on a pending request.
  - WAIT_FRAME → BLANK on `frame_start` when BLANK_FRAMES > 0. The blank counter loads BLANK_FRAMES-1.
  - WAIT_FRAME → RUN on `frame_start` when BLANK_FRAMES = 0. `cur_sel` takes `pend_sel` on the same edge.
  - BLANK: each `frame_start` with counter = 0 → RUN, and `cur_sel` takes `pend_sel`. Otherwise the counter decrements.
- **`switching`** is high in WAIT_FRAME and BLANK.
- **Requests during WAIT_FRAME/BLANK:** `pend_sel` is not updated. After returning to RUN, a still-differing `sel_s` starts a new switch.
- **Base pixel:**
  - `src_pix[cur_sel]` if `cur_sel < NUM_SRC`, else DEFAULT_PIX.
  - In WAIT_FRAME the old source keeps displaying.
  - In BLANK the base pixel is 0.
- **Overlay:** applies only when `ovl_en_s` is set, `ovl_sel_s < NUM_SRC` and the state is not BLANK. The overlay pixel `src_pix[ovl_sel_s]` replaces the base pixel when it differs from KEY_PIX. Overlay changes need no frame alignment.
- **Final pixel:** 0 whenever `pix_active` is low. No colour is ever driven in porch or sync periods.

## Timing
- **Latency:** exactly 1 clock. `o_pix` and `o_active` at edge n+1 reflect the inputs at edge n, including `cur_sel` and state at edge n.
- **Synchroniser delay:** 2 clocks from a `sel` pin change to `sel_s`. A switch therefore completes on the first `frame_start` at least 3 clocks after the pin change, plus BLANK_FRAMES frames.
- **Reset values (asynchronous):**
  - `o_pix` = 0, `o_active` = 0, `cur_sel` = 0, `switching` = 0.
  - FSM = RUN, synchronisers = 0, blank counter = 0.
  - Once running, a nonzero `sel` initiates a normal switch.
- **Reset mid-switch:** the switch aborts and `cur_sel` returns to 0.
- **`frame_start` together with a new request in RUN:** the request enters WAIT_FRAME and waits for the next `frame_start`. Switching never happens mid-frame.
- **Width rules:**
  - Select compares are unsigned, SEL_W bits.
  - The blank counter is 4 bits.
  - Overlay key compare is a full 3*CW-bit equality.

## Structure
- A shared package `vga_pkg` holds the pixel width function (3*CW), the FSM state encoding and `DEFAULT_PIX`/`KEY_PIX` defaults. `vga_display` and the generators reuse these.
- One sub-module, `sync_2ff`, parametrised by width and used for the three async inputs.
- `src_pix` indexing uses an indexed part-select. No per-source generate muxes are required.

## Test plan
All scenarios use NUM_SRC=4, CW=4.
- **Reset:** assert `rst` mid-frame → `o_pix`=000, `cur_sel`=0, `switching`=0 immediately, without waiting for `clk`.
- **Switch, no blank:** BLANK_FRAMES=0, sel 0→2 mid-frame, src2=0x0F0 → `switching`=1 within 3 clocks. Source 0 stays until the next `frame_start`. From that edge `cur_sel`=2, and one clock later `o_pix`=0x0F0 when active.
- **Switch with blank:** BLANK_FRAMES=2, sel 1→3 → two full frames of `o_pix`=000 with `o_active` toggling. The third frame shows src3 and `switching` drops at its `frame_start`.
- **Out-of-range select:** sel=5 → after the frame switch `o_pix`=DEFAULT_PIX (0xFFF) during active video and 000 outside it.
- **Overlay keying:** base src0=0x00F, overlay src1 alternating 0x000/0xF00, `ovl_en`=1 → `o_pix` alternates 0x00F/0xF00. Repeat during BLANK → 000.
- **Request during blank:** request 0→1, then change sel to 2 during BLANK → the switch completes to 1, then a second switch runs to 2 on a later frame. No mid-frame change is observed.
